spart_tx_sched: RTL

//  Round-robin scheduler that shares one SPART transmitter between NREQ byte sources.

---
 rtl/spart_tx_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spart_tx_sched.sv
// spart_tx_sched: round-robin arbiter that shares one SPART transmitter
// between NREQ byte sources. A winner is launched with a one-cycle tx_en/ack
// pulse, and the frame is then timed in baud ticks before the next grant.
module spart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int FRAME_TICKS = 10,
  parameter int GAP_TICKS   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    baud_clk,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_TICKS - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_TICKS - 1);

  logic [1:0]      state;
  logic [3:0]      tick_cnt;
  logic [PW-1:0]   rr_ptr;

  logic [PW-1:0]   cand;
  logic [PW-1:0]   win;
  logic            found;
  logic [PW-1:0]   win_next_ptr;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      win_data;

  // Round-robin search: walk from rr_ptr upward (modulo NREQ); scanning in
  // reverse and overwriting leaves the first pending index in the search order.
  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Decode the winner into its ack bit, its byte and the pointer after it.
  always_comb begin
    win_onehot   = '0;
    win_data     = 8'h00;
    win_next_ptr = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
  end

  // Scheduler FSM: launch in IDLE, count frame ticks in SEND (ignoring a tick
  // that lands on the tx_en cycle), then optional idle ticks in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      rr_ptr   <= '0;
      ack      <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      owner    <= '0;
    end else begin
      ack   <= '0;
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_en    <= 1'b1;
            ack      <= win_onehot;
            tx_data  <= win_data;
            owner    <= win;
            busy     <= 1'b1;
            tick_cnt <= 4'd0;
            rr_ptr   <= win_next_ptr;
            state    <= SEND;
          end else begin
            busy <= 1'b0;
          end
        end
        SEND: begin
          if (baud_clk && !tx_en) begin
            if (tick_cnt == FRAME_LAST) begin
              tick_cnt <= 4'd0;
              if (GAP_TICKS > 0) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        GAP: begin
          if (baud_clk) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt <= 4'd0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= 4'd0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
